pifo_sorter: RTL

- Register-based push-in-first-out (PIFO) queue directly downstream of the round-robin rank stage in the rank pipe.
- Pulls {rank, meta} pairs from the rank stage's output FIFO through a valid/ready handshake and keeps them sorted by rank in a shift-register array.
- Presents the minimum-rank entry to the output scheduler; pops on demand.
- Equal ranks leave in arrival order (FIFO among ties).

---
 rtl/pifo_pkg.sv | 27 ++
 rtl/pifo_sorter_cell.sv | 91 +++++++++
 rtl/pifo_sorter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pifo_pkg.sv
// Shared types and defaults for the register-based PIFO sorter.
package pifo_pkg;

  localparam int RANK_W_DEF = 16;
  localparam int META_W_DEF = 16;
  localparam int DEPTH_DEF  = 16;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(DEPTH_DEF);

  typedef struct packed {
    logic                  vld;
    logic [RANK_W_DEF-1:0] rank;
    logic [META_W_DEF-1:0] meta;
  } slot_t;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_LEFT,
    SEL_RIGHT,
    SEL_NEW
  } sel_e;

endpackage

// File: rtl/pifo_sorter_cell.sv
// One PIFO slot: holds {vld, rank, meta} and picks its next value
// from hold, lower neighbour, upper neighbour or the incoming entry.
module pifo_sorter_cell
  import pifo_pkg::*;
#(
  parameter int RANK_WIDTH = RANK_W_DEF,
  parameter int META_WIDTH = META_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [RANK_WIDTH-1:0] rank_in,
  input  logic [META_WIDTH-1:0] meta_in,
  input  logic                  ins_here,
  input  logic                  ins_above,
  input  logic                  gt_prev,
  input  logic                  gt_next,
  input  logic                  l_vld,
  input  logic [RANK_WIDTH-1:0] l_rank,
  input  logic [META_WIDTH-1:0] l_meta,
  input  logic                  r_vld,
  input  logic [RANK_WIDTH-1:0] r_rank,
  input  logic [META_WIDTH-1:0] r_meta,
  output logic                  vld,
  output logic [RANK_WIDTH-1:0] rank,
  output logic [META_WIDTH-1:0] meta,
  output logic                  gt
);

  logic                  vld_q, vld_d;
  logic [RANK_WIDTH-1:0] rank_q, rank_d;
  logic [META_WIDTH-1:0] meta_q, meta_d;
  sel_e                  sel;

  assign gt   = ~vld_q | (rank_in < rank_q);
  assign vld  = vld_q;
  assign rank = rank_q;
  assign meta = meta_q;

  // Push+pop: slot i takes the entry meant for slot i+1 pre-shift.
  always_comb begin
    sel = SEL_HOLD;
    if (push && pop) begin
      if (ins_above)     sel = SEL_NEW;
      else if (!gt_next) sel = SEL_RIGHT;
    end else if (push) begin
      if (ins_here)      sel = SEL_NEW;
      else if (gt_prev)  sel = SEL_LEFT;
    end else if (pop) begin
      sel = SEL_RIGHT;
    end
  end

  always_comb begin
    vld_d  = vld_q;
    rank_d = rank_q;
    meta_d = meta_q;
    unique case (sel)
      SEL_LEFT: begin
        vld_d  = l_vld;
        rank_d = l_rank;
        meta_d = l_meta;
      end
      SEL_RIGHT: begin
        vld_d  = r_vld;
        rank_d = r_rank;
        meta_d = r_meta;
      end
      SEL_NEW: begin
        vld_d  = 1'b1;
        rank_d = rank_in;
        meta_d = meta_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      rank_q <= '0;
      meta_q <= '0;
    end else begin
      vld_q  <= vld_d;
      rank_q <= rank_d;
      meta_q <= meta_d;
    end
  end

endmodule

// File: rtl/pifo_sorter.sv
// Shift-register PIFO: keeps entries sorted by rank, minimum at slot 0,
// FIFO order among equal ranks.
module pifo_sorter
  import pifo_pkg::*;
#(
  parameter int RANK_WIDTH = RANK_W_DEF,
  parameter int META_WIDTH = META_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_WIDTH  = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RANK_WIDTH-1:0] rank_in,
  input  logic [META_WIDTH-1:0] meta_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RANK_WIDTH-1:0] rank_out,
  output logic [META_WIDTH-1:0] meta_out,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full
);

  logic [DEPTH-1:0]      vld_w;
  logic [DEPTH-1:0]      gt_w;
  logic [DEPTH:0]        ins;
  logic [RANK_WIDTH-1:0] rank_w [DEPTH];
  logic [META_WIDTH-1:0] meta_w [DEPTH];
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  push, pop;

  assign full      = (count_q == CNT_WIDTH'(DEPTH));
  assign in_ready  = ~full;
  assign out_valid = vld_w[0];
  assign rank_out  = rank_w[0];
  assign meta_out  = meta_w[0];
  assign count     = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // gt_w is a thermometer code; its rising edge marks the insert slot.
  assign ins[0]     = gt_w[0];
  assign ins[DEPTH] = ~gt_w[DEPTH-1];
  for (genvar i = 1; i < DEPTH; i++) begin : g_ins
    assign ins[i] = gt_w[i] & ~gt_w[i-1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic                  gt_prev, gt_next, ins_above;
    logic                  l_vld, r_vld;
    logic [RANK_WIDTH-1:0] l_rank, r_rank;
    logic [META_WIDTH-1:0] l_meta, r_meta;

    if (i == 0) begin : g_lo
      // A new minimum during push+pop replaces the popped head.
      assign ins_above = ins[1] | ins[0];
      assign gt_prev   = 1'b0;
      assign l_vld     = 1'b0;
      assign l_rank    = '0;
      assign l_meta    = '0;
    end else begin : g_lo
      assign ins_above = ins[i+1];
      assign gt_prev   = gt_w[i-1];
      assign l_vld     = vld_w[i-1];
      assign l_rank    = rank_w[i-1];
      assign l_meta    = meta_w[i-1];
    end

    if (i == DEPTH-1) begin : g_hi
      assign gt_next = 1'b1;
      assign r_vld   = 1'b0;
      assign r_rank  = '0;
      assign r_meta  = '0;
    end else begin : g_hi
      assign gt_next = gt_w[i+1];
      assign r_vld   = vld_w[i+1];
      assign r_rank  = rank_w[i+1];
      assign r_meta  = meta_w[i+1];
    end

    pifo_sorter_cell #(
      .RANK_WIDTH(RANK_WIDTH),
      .META_WIDTH(META_WIDTH)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .rank_in  (rank_in),
      .meta_in  (meta_in),
      .ins_here (ins[i]),
      .ins_above(ins_above),
      .gt_prev  (gt_prev),
      .gt_next  (gt_next),
      .l_vld    (l_vld),
      .l_rank   (l_rank),
      .l_meta   (l_meta),
      .r_vld    (r_vld),
      .r_rank   (r_rank),
      .r_meta   (r_meta),
      .vld      (vld_w[i]),
      .rank     (rank_w[i]),
      .meta     (meta_w[i]),
      .gt       (gt_w[i])
    );
  end

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      push && !pop: count_d = count_q + 1'b1;
      pop && !push: count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule
